// File: rtl/rf_wb_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
package rf_wb_ctrl_pkg;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Result handshake from the producers plus the register-file write port.
interface rf_wb_ctrl_if;
    import rf_wb_ctrl_pkg::*;

    logic              res_valid;
    logic [SEL_W-1:0]  res_sel;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic [SEL_W-1:0]  writeregsel;
    logic [DATA_W-1:0] writedata;
    logic              write;

    modport master (
        output res_valid, res_sel, res_data,
        input  res_ready, writeregsel, writedata, write
    );

    modport slave (
        input  res_valid, res_sel, res_data,
        output res_ready, writeregsel, writedata, write
    );
endinterface

// File: rtl/rf_wb_ctrl_wb_fifo.sv
// DEPTH-entry result FIFO; pointers carry a wrap bit to tell full from empty.
module wb_fifo
    import rf_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      empty,
    output logic      full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    wb_entry_t   mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible through the empty mask.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller: buffers results, drains one per cycle into the
// register file and tracks pending writes per register for hazard detection.
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    rf_wb_ctrl_if.slave         wb,
    input  logic                alloc,
    input  logic [SEL_W-1:0]    alloc_sel,
    input  logic                hold,
    input  logic [SEL_W-1:0]    chk1sel,
    input  logic [SEL_W-1:0]    chk2sel,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic                err
);
    logic      empty, full, push, pop;
    wb_entry_t head, din;

    assign pop          = !empty && !hold;
    assign wb.res_ready = !full || pop;
    assign push         = wb.res_valid && wb.res_ready;
    assign din          = '{sel: wb.res_sel, data: wb.res_data};

    assign wb.write       = pop;
    assign wb.writeregsel = empty ? '0 : head.sel;
    assign wb.writedata   = empty ? '0 : head.data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .empty (empty),
        .full  (full)
    );

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt, cnt_nxt;
    logic [NUM_REGS-1:0]            inc, dec;
    logic                           err_hit;

    always_comb begin
        inc = '0;
        dec = '0;
        if (alloc) inc[alloc_sel] = 1'b1;
        if (pop)   dec[head.sel]  = 1'b1;
    end

    // Coincident alloc and pop cancel; overflow and underflow saturate and flag.
    always_comb begin
        cnt_nxt = cnt;
        err_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            case ({inc[i], dec[i]})
                2'b10: begin
                    if (cnt[i] == CNT_MAX) err_hit = 1'b1;
                    else                   cnt_nxt[i] = cnt[i] + 1'b1;
                end
                2'b01: begin
                    if (cnt[i] == '0) err_hit = 1'b1;
                    else              cnt_nxt[i] = cnt[i] - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            err <= err | err_hit;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
        assign busy[g] = |cnt[g];
    end

    assign stall = busy[chk1sel] | busy[chk2sel];
endmodule
